// File: rtl/flash_fetch_pkg.sv
// Shared definitions for the flash sample fetcher.
//   - fetch_state_t : 2-bit FSM encoding IDLE / REQ / WAIT_DATA / SELECT
//   - FLASH_DATA_W  : Avalon flash data width (one 32-bit word)
//   - SAMPLE_W      : audio sample width (one half of a flash word)
//   - BYTEEN_ALL    : byte enable for whole-word reads
//   - pick_half()   : selects the 16-bit half of a flash word
package flash_fetch_pkg;

  localparam int FLASH_DATA_W = 32;
  localparam int SAMPLE_W     = 16;
  localparam logic [3:0] BYTEEN_ALL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2,
    SELECT    = 2'd3
  } fetch_state_t;

  function automatic logic [SAMPLE_W-1:0] pick_half(
    input logic [FLASH_DATA_W-1:0] word,
    input logic                    hi
  );
    return hi ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/sample_tick_detect.sv
// Turns the asynchronous divided sampling clock into a one-cycle request
// pulse in the CLK_50M domain.
// Ports:
//   CLK_50M    in  system clock
//   RESET_N    in  asynchronous active-low reset
//   sample_clk in  divided sampling clock (level, asynchronous)
//   tick       out one-cycle pulse, high in the third cycle after the
//                  sample_clk rising edge is first sampled
module sample_tick_detect (
  input  logic CLK_50M,
  input  logic RESET_N,
  input  logic sample_clk,
  output logic tick
);

  // sync1/sync2 form the synchroniser; sync3 is the previous value of the
  // synchronised level for edge detection. tick is registered so that the
  // request reaches the FSM as a clean, glitch-free flop output.
  logic sync1, sync2, sync3;

  always_ff @(posedge CLK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      tick  <= 1'b0;
    end else begin
      sync1 <= sample_clk;
      sync2 <= sync1;
      sync3 <= sync2;
      tick  <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/flash_sample_fetcher.sv
// Fetches one 16-bit audio sample per sampling-clock edge from a 32-bit
// Avalon-MM flash port, with a one-word cache so the second half of a word
// needs no flash read.
// Optional feature macro: FETCH_TIMEOUT_EN (per-fetch watchdog, sticky
// timeout_err). Without it the fetcher waits indefinitely for read data.
// Ports:
//   CLK_50M, RESET_N           clock, asynchronous active-low reset
//   sample_clk                 divided sampling clock; rising edge = request
//   pause                      1 = emit silence and skip the flash read
//   address, high_low_half     word address and half select from the counter
//   flash_mem_*                Avalon-MM read master
//   sample_out, sample_valid   registered sample and one-cycle update strobe
//   busy                       FSM not in IDLE
//   overrun                    one-cycle pulse: request dropped while busy
//   timeout_err                sticky watchdog flag
//   fsm_state                  current FSM state (debug)
//
// Avalon read handshake: flash_mem_read is held high with a stable
// flash_mem_address until a cycle in which flash_mem_waitrequest is low;
// that cycle accepts the request and read drops on the next edge. The word
// returns later in the single cycle where flash_mem_readdatavalid is high.
module flash_sample_fetcher
  import flash_fetch_pkg::*;
#(
  parameter int ADDR_W         = 23,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    CLK_50M,
  input  logic                    RESET_N,
  input  logic                    sample_clk,
  input  logic                    pause,
  input  logic [31:0]             address,
  input  logic                    high_low_half,
  output logic                    flash_mem_read,
  output logic [ADDR_W-1:0]       flash_mem_address,
  output logic [3:0]              flash_mem_byteenable,
  input  logic                    flash_mem_waitrequest,
  input  logic                    flash_mem_readdatavalid,
  input  logic [FLASH_DATA_W-1:0] flash_mem_readdata,
  output logic [SAMPLE_W-1:0]     sample_out,
  output logic                    sample_valid,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout_err,
  output logic [1:0]              fsm_state
);

  fetch_state_t            state;
  logic                    tick;
  logic                    lat_half;
  logic                    lat_pause;
  logic                    cache_valid;
  logic [ADDR_W-1:0]       cache_addr;
  logic [FLASH_DATA_W-1:0] cache_word;
  logic                    wd_fire;

  // Upper address bits beyond the flash window are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[31:ADDR_W];

  assign flash_mem_byteenable = BYTEEN_ALL;
  assign busy                 = (state != IDLE);
  assign fsm_state            = state;

  sample_tick_detect u_tick (
    .CLK_50M    (CLK_50M),
    .RESET_N    (RESET_N),
    .sample_clk (sample_clk),
    .tick       (tick)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  // Fires on the edge that ends the TIMEOUT_CYCLES-th cycle in REQ/WAIT_DATA.
  assign wd_fire = ((state == REQ) || (state == WAIT_DATA)) && (wd_cnt == WD_LAST);

  always_ff @(posedge CLK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == REQ) || (state == WAIT_DATA)) wd_cnt <= wd_cnt + WD_W'(1);
      else                                        wd_cnt <= '0;
      if (wd_fire) timeout_err <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign wd_fire            = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  always_ff @(posedge CLK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      state             <= IDLE;
      flash_mem_read    <= 1'b0;
      flash_mem_address <= '0;
      lat_half          <= 1'b0;
      lat_pause         <= 1'b0;
      cache_valid       <= 1'b0;
      cache_addr        <= '0;
      cache_word        <= '0;
      sample_out        <= '0;
      sample_valid      <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      // Requests are never queued: a tick outside IDLE is only reported.
      overrun      <= tick && (state != IDLE);

      if (wd_fire) begin
        // Abandon the fetch; the cached word may be stale, so drop it.
        state          <= IDLE;
        flash_mem_read <= 1'b0;
        sample_out     <= '0;
        sample_valid   <= 1'b1;
        cache_valid    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (tick) begin
              flash_mem_address <= address[ADDR_W-1:0];
              lat_half          <= high_low_half;
              lat_pause         <= pause;
              if (pause || (cache_valid && (cache_addr == address[ADDR_W-1:0]))) begin
                state <= SELECT;
              end else begin
                state          <= REQ;
                flash_mem_read <= 1'b1;
              end
            end
          end
          REQ: begin
            if (!flash_mem_waitrequest) begin
              flash_mem_read <= 1'b0;
              state          <= WAIT_DATA;
            end
          end
          WAIT_DATA: begin
            if (flash_mem_readdatavalid) begin
              cache_word  <= flash_mem_readdata;
              cache_addr  <= flash_mem_address;
              cache_valid <= 1'b1;
              state       <= SELECT;
            end
          end
          SELECT: begin
            // A pause seen at the request or now yields silence; a fetch
            // already under way still refills the cache.
            sample_out   <= (pause || lat_pause) ? '0 : pick_half(cache_word, lat_half);
            sample_valid <= 1'b1;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
